// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds the CPU in reset, runs it, and
// judges the result by watching data-memory writes to selected addresses.
// Ports:
//   clk, reset (sync active-high), start, halt          control inputs
//   mem_we, mem_addr, mem_wdata                         observed write bus
//   watch_addr, watch_exp                               channel i in slice i
//   cpu_reset, busy, done, pass, timeout, cycle_count   run status
//   watch_hit, watch_ok                                 per-channel flags
// Optional feature: define CPU_RUN_CYCLE_LIMIT_EN to end a run that
// reaches MAX_CYCLES-1 run cycles without halt (timeout=1).
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 20,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_WATCH    = 2,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        halt,
  input  logic                        mem_we,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_wdata,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
  input  logic [NUM_WATCH*DATA_W-1:0] watch_exp,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [NUM_WATCH-1:0]        watch_hit,
  output logic [NUM_WATCH-1:0]        watch_ok
);

  typedef enum logic [1:0] {
    S_IDLE, S_RST, S_RUN, S_DONE
  } state_e;

  localparam int RW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

  state_e              state_q, state_d;
  logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   cap_q [NUM_WATCH];
  logic [DATA_W-1:0]   cap_d [NUM_WATCH];
  logic [NUM_WATCH-1:0] hit_q, hit_d;
  logic [NUM_WATCH-1:0] ok_q, ok_d;
  logic [NUM_WATCH-1:0] wr_match, fin_ok;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic to_q, to_d;
  logic cpu_reset_q, cpu_reset_d;
  logic busy_q, busy_d;
  logic limit_hit;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef CPU_RUN_CYCLE_LIMIT_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);
  assign limit_hit = (cnt_inc == LIMIT);
`else
  logic unused_max;
  assign unused_max = ^(32'(MAX_CYCLES));
  assign limit_hit  = 1'b0;
`endif

  // fin_ok folds in a write landing on the final RUN cycle so pass is
  // correct in the very first DONE cycle.
  always_comb begin
    for (int i = 0; i < NUM_WATCH; i++) begin
      wr_match[i] = (state_q == S_RUN) && mem_we &&
        (mem_addr == watch_addr[i*ADDR_W +: ADDR_W]);
      fin_ok[i] = wr_match[i]
        ? (mem_wdata == watch_exp[i*DATA_W +: DATA_W])
        : (hit_q[i] &&
           (cap_q[i] == watch_exp[i*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    hit_d     = hit_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
    for (int i = 0; i < NUM_WATCH; i++) begin
      ok_d[i] = hit_q[i] &&
        (cap_q[i] == watch_exp[i*DATA_W +: DATA_W]);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          cnt_d     = '0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        else rst_cnt_d = rst_cnt_q + RW'(1);
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        for (int i = 0; i < NUM_WATCH; i++) begin
          if (wr_match[i]) begin
            hit_d[i] = 1'b1;
            cap_d[i] = mem_wdata;
          end
        end
        if (halt || limit_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          to_d    = limit_hit && !halt;
          pass_d  = (&fin_ok) && !(limit_hit && !halt);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          cnt_d     = '0;
          hit_d     = '0;
          ok_d      = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          to_d      = 1'b0;
          for (int i = 0; i < NUM_WATCH; i++) cap_d[i] = '0;
        end
      end
    endcase
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d == S_RST) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      hit_q       <= '0;
      ok_q        <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      to_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_WATCH; i++) cap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      ok_q        <= ok_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      to_q        <= to_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NUM_WATCH; i++) cap_q[i] <= cap_d[i];
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = to_q;
  assign cycle_count = cnt_q;
  assign watch_hit   = hit_q;
  assign watch_ok    = ok_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-cycle comparison against a run-level model
// plus hand-computed checkpoints for each directed scenario.
module tb_cpu_run_ctrl;
  localparam int RC = 4, MC = 20, AW = 32, DW = 32, NW = 2, CW = 16;
`ifdef CPU_RUN_CYCLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, halt, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NW*AW-1:0] watch_addr;
  logic [NW*DW-1:0] watch_exp;
  logic cpu_reset, busy, done, pass, timeout;
  logic [CW-1:0] cycle_count;
  logic [NW-1:0] watch_hit, watch_ok;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .watch_addr(watch_addr), .watch_exp(watch_exp),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycle_count(cycle_count),
    .watch_hit(watch_hit), .watch_ok(watch_ok)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 reset-hold, 2 running, 3 finished.
  int m_phase, m_hold, m_cnt;
  bit m_hit [NW];
  bit m_ok [NW];
  logic [DW-1:0] m_cap [NW];
  bit m_done, m_pass, m_to;

  function automatic logic [AW-1:0] waddr(int i);
    return watch_addr[i*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] wexp(int i);
    return watch_exp[i*DW +: DW];
  endfunction

  always @(posedge clk) begin
    bit lag_ok [NW];
    for (int i = 0; i < NW; i++)
      lag_ok[i] = m_hit[i] && (m_cap[i] == wexp(i));
    if (reset) begin
      m_phase = 0; m_hold = 0; m_cnt = 0;
      m_done = 0; m_pass = 0; m_to = 0;
      for (int i = 0; i < NW; i++) begin
        m_hit[i] = 0; m_ok[i] = 0; m_cap[i] = '0;
      end
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_hold = RC; m_cnt = 0; end
        1: begin
          m_hold = m_hold - 1;
          if (m_hold == 0) m_phase = 2;
        end
        2: begin
          for (int i = 0; i < NW; i++)
            if (mem_we && mem_addr == waddr(i)) begin
              m_hit[i] = 1; m_cap[i] = mem_wdata;
            end
          if (m_cnt < (2**CW) - 1) m_cnt = m_cnt + 1;
          if (halt || (LIM && m_cnt == MC - 1)) begin
            m_phase = 3; m_done = 1; m_to = !halt;
            m_pass = !m_to;
            for (int i = 0; i < NW; i++)
              if (!(m_hit[i] && m_cap[i] == wexp(i))) m_pass = 0;
          end
        end
        default: if (start) begin
          m_phase = 1; m_hold = RC; m_cnt = 0;
          m_done = 0; m_pass = 0; m_to = 0;
          for (int i = 0; i < NW; i++) begin
            m_hit[i] = 0; m_cap[i] = '0; lag_ok[i] = 0;
          end
        end
      endcase
      for (int i = 0; i < NW; i++) m_ok[i] = lag_ok[i];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NW-1:0] eh, eo;
      logic ecr, eb;
      for (int i = 0; i < NW; i++) begin
        eh[i] = m_hit[i]; eo[i] = m_ok[i];
      end
      ecr = (m_phase != 2);
      eb  = (m_phase == 1) || (m_phase == 2);
      vec++;
      if ({cpu_reset, busy, done, pass, timeout, cycle_count,
           watch_hit, watch_ok} !==
          {ecr, eb, m_done, m_pass, m_to, CW'(m_cnt), eh, eo}) begin
        err++;
        $display("FAIL cycle t=%0t got cr%b b%b d%b p%b to%b cnt%0d h%b ok%b expected cr%b b%b d%b p%b to%b cnt%0d h%b ok%b",
          $time, cpu_reset, busy, done, pass, timeout, cycle_count,
          watch_hit, watch_ok, ecr, eb, m_done, m_pass, m_to, m_cnt,
          eh, eo);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    int g = 0;
    while (cpu_reset && g < 50) begin
      if (busy) n++;
      g++;
      @(negedge clk);
    end
    lit("rst_len", n, RC);
    lit("run_entry", {cpu_reset, busy, cycle_count}, {1'b0, 1'b1, 16'd0});
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic h);
    mem_we = we; mem_addr = a; mem_wdata = d; halt = h;
    @(negedge clk);
    mem_we = 0; mem_addr = '0; mem_wdata = '0; halt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; halt = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0;
    watch_addr = {32'h10, 32'h0C};
    watch_exp  = {32'h7, 32'h5};
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("rst_outs", {cpu_reset, busy, done, pass, timeout,
                     cycle_count, watch_hit, watch_ok},
        {1'b1, 1'b0, 3'b000, 16'd0, 4'b0000});
    reset = 0;
    cyc(1, 32'h0C, 5, 0);
    lit("idle_write", watch_hit, 0);

    // basic pass run, last write lands with halt
    do_start();
    wait_run();
    cyc(1, 32'h0C, 5, 0);
    for (int k = 2; k <= 7; k++) cyc(0, 0, 0, 0);
    cyc(1, 32'h10, 7, 1);
    lit("a_done", {done, pass, timeout, busy, cpu_reset},
        5'b11001);
    lit("a_cnt", cycle_count, 8);
    cyc(1, 32'h0C, 3, 0);
    lit("a_done_write", {watch_hit, watch_ok, pass}, 5'b11111);

    // overwrite: 3 then 5
    do_start();
    lit("b_clear", {done, pass, watch_hit, watch_ok}, 0);
    wait_run();
    cyc(1, 32'h0C, 3, 0);
    lit("b_hit0", {watch_hit[0], watch_ok[0]}, 2'b10);
    start = 1;
    cyc(1, 32'h10, 7, 0);
    start = 0;
    lit("b_ok0_bad", watch_ok[0], 0);
    cyc(1, 32'h0C, 5, 0);
    lit("b_ok0_lag", watch_ok[0], 0);
    cyc(0, 0, 0, 0);
    lit("b_ok0_good", watch_ok[0], 1);
    cyc(0, 0, 0, 1);
    lit("b_done", {done, pass, cycle_count}, {2'b11, 16'd5});

    // last value wrong -> fail
    do_start();
    wait_run();
    cyc(1, 32'h0C, 5, 0);
    cyc(1, 32'h10, 7, 0);
    cyc(1, 32'h0C, 4, 1);
    lit("c_fail", {done, pass, timeout, cycle_count},
        {3'b100, 16'd3});

    // reset mid-run, then clean run
    do_start();
    wait_run();
    cyc(1, 32'h0C, 5, 0);
    for (int k = 2; k <= 4; k++) cyc(0, 0, 0, 0);
    reset = 1;
    cyc(0, 0, 0, 0);
    reset = 0;
    lit("d_reset", {cpu_reset, busy, done, pass, timeout,
                    cycle_count, watch_hit, watch_ok},
        {1'b1, 1'b0, 3'b000, 16'd0, 4'b0000});
    do_start();
    wait_run();
    cyc(1, 32'h0C, 5, 0);
    cyc(1, 32'h10, 7, 1);
    lit("d_rerun", {done, pass, cycle_count}, {2'b11, 16'd2});

    // both channels on one address
    watch_addr = {32'h20, 32'h20};
    watch_exp  = {32'h9, 32'h9};
    do_start();
    wait_run();
    cyc(1, 32'h20, 9, 0);
    cyc(0, 0, 0, 1);
    lit("e_dup", {watch_hit, watch_ok, pass}, 5'b11111);
    watch_addr = {32'h10, 32'h0C};
    watch_exp  = {32'h7, 32'h5};

    if (LIM) begin
      do_start();
      wait_run();
      for (int k = 0; k < 40 && !done; k++) cyc(0, 0, 0, 0);
      lit("f_timeout", {done, pass, timeout, cycle_count},
          {3'b101, 16'd19});
      do_start();
      wait_run();
      cyc(1, 32'h0C, 5, 0);
      cyc(1, 32'h10, 7, 0);
      for (int k = 3; k <= 18; k++) cyc(0, 0, 0, 0);
      lit("f_not_yet", {done, busy}, 2'b01);
      cyc(0, 0, 0, 1);
      lit("f_halt_wins", {done, pass, timeout, cycle_count},
          {3'b110, 16'd19});
    end else begin
      do_start();
      wait_run();
      for (int k = 0; k < 100; k++) cyc(0, 0, 0, 0);
      lit("f_long", {cpu_reset, busy, done, timeout, cycle_count},
          {4'b0100, 16'd100});
      cyc(0, 0, 0, 1);
      lit("f_end", {done, timeout, cycle_count}, {2'b10, 16'd101});
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
